// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: takes one ALU result per start pulse, performs an
// optional data-memory read or write with timeout, and produces a writeback result.
module mem_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [15:0] wb_data,
    output logic        err
);

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_LBU = 4'h9;
    localparam logic [3:0] OP_LBS = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       sdata_q, sdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       wb_data_q, wb_data_d;
    logic              wb_en_q, wb_en_d;
    logic              err_q, err_d;

    logic        accept;
    logic        in_is_mem;
    logic        in_misaligned;
    logic        req_timeout;
    logic        req_is_sw;
    logic [7:0]  load_byte;
    logic [15:0] load_value;

    function automatic logic is_mem_op(input logic [3:0] o);
        return (o == OP_LW) || (o == OP_LBU) || (o == OP_LBS) || (o == OP_SW);
    endfunction

    assign accept        = (state_q == S_IDLE) && start;
    assign in_is_mem     = is_mem_op(op);
    assign in_misaligned = ((op == OP_LW) || (op == OP_SW)) && alu_result[0];
    assign req_timeout   = (cnt_q == CNT_LAST);
    assign req_is_sw     = (op_q == OP_SW);

    // Byte loads pick the lane from the low address bit; only LBs sign-extends.
    always_comb begin
        load_byte  = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        load_value = mem_rdata;
        if (op_q == OP_LBU) begin
            load_value = {8'h00, load_byte};
        end else if (op_q == OP_LBS) begin
            load_value = {{8{load_byte[7]}}, load_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (in_is_mem && !in_misaligned) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack || req_timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Captured operands and the result registers change only on accept or REQ exit.
    always_comb begin
        op_d      = op_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_en_d   = wb_en_q;
        err_d     = err_q;
        if (accept) begin
            op_d    = op;
            addr_d  = alu_result;
            sdata_d = store_data;
            cnt_d   = '0;
            if (!in_is_mem) begin
                wb_data_d = alu_result;
                wb_en_d   = 1'b1;
                err_d     = 1'b0;
            end else if (in_misaligned) begin
                wb_en_d = 1'b0;
                err_d   = 1'b1;
            end
        end else if (state_q == S_REQ) begin
            if (mem_ack) begin
                err_d = 1'b0;
                if (req_is_sw) begin
                    wb_en_d = 1'b0;
                end else begin
                    wb_en_d   = 1'b1;
                    wb_data_d = load_value;
                end
            end else if (req_timeout) begin
                wb_en_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            op_q      <= op_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            err_q     <= err_d;
        end
    end

    // Memory-side outputs are forced to zero whenever no request is outstanding.
    always_comb begin
        mem_req   = (state_q == S_REQ);
        mem_we    = mem_req && req_is_sw;
        mem_addr  = mem_req ? {addr_q[15:1], 1'b0} : 16'h0000;
        mem_wdata = mem_we ? sdata_q : 16'h0000;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        wb_en     = done && wb_en_q;
        err       = done && err_q;
        wb_data   = wb_data_q;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random transactions checked
// against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int TIMEOUT = 15;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_LBU = 4'h9;
    localparam logic [3:0] OP_LBS = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [15:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_wb = 16'h0000;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .alu_result(alu_result), .store_data(store_data),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .wb_en(wb_en), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_is_mem(input logic [3:0] o);
        return (o == OP_LW) || (o == OP_LBU) || (o == OP_LBS) || (o == OP_SW);
    endfunction

    function automatic logic [15:0] model_load(input logic [3:0] o, input logic [15:0] a,
                                               input logic [15:0] rd);
        int b;
        b = a[0] ? int'(rd) / 256 : int'(rd) % 256;
        if (o == OP_LW)  return rd;
        if (o == OP_LBU) return 16'(b);
        return (b >= 128) ? 16'(b + 65280) : 16'(b);
    endfunction

    // One complete transaction; ackdly = REQ cycle index in which ack is given
    // (values >= TIMEOUT mean no ack ever arrives).
    task automatic run_txn(input logic [3:0] o, input logic [15:0] a, input logic [15:0] sd,
                           input logic [15:0] rd, input int ackdly, input bit spurious);
        bit misal, goes_req, exp_wben, exp_err;
        logic [15:0] exp_wb;
        misal    = ((o == OP_LW) || (o == OP_SW)) && a[0];
        goes_req = model_is_mem(o) && !misal;
        exp_wben = 1'b0;
        exp_err  = 1'b0;
        exp_wb   = last_wb;
        start = 1'b1; op = o; alu_result = a; store_data = sd;
        step();
        start = 1'b0;
        if (!model_is_mem(o)) begin
            exp_wben = 1'b1; exp_wb = a;
        end else if (misal) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; ; i++) begin
                check("req_active", mem_req, 1'b1);
                check("req_busy", busy, 1'b1);
                check("req_no_done", done, 1'b0);
                check("req_addr", mem_addr, {a[15:1], 1'b0});
                check("req_we", mem_we, (o == OP_SW));
                check("req_wdata", mem_wdata, (o == OP_SW) ? sd : 16'h0000);
                if (spurious && i == 0) begin
                    start = 1'b1; op = OP_ADD; alu_result = 16'hFFFF; store_data = 16'h1111;
                end
                mem_ack   = (i == ackdly);
                mem_rdata = (i == ackdly) ? rd : 16'($urandom);
                step();
                start = 1'b0; mem_ack = 1'b0;
                if (i == ackdly || i == TIMEOUT - 1) break;
            end
            if (ackdly < TIMEOUT) begin
                if (o != OP_SW) begin
                    exp_wben = 1'b1; exp_wb = model_load(o, a, rd);
                end
            end else begin
                exp_err = 1'b1;
            end
        end
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b1);
        check("done_req_low", mem_req, 1'b0);
        check("done_addr_zero", mem_addr, 16'h0000);
        check("done_wben", wb_en, exp_wben);
        check("done_err", err, exp_err);
        if (exp_wben) begin
            check("done_wbdata", wb_data, exp_wb);
            last_wb = exp_wb;
        end
        mem_ack = 1'($urandom);
        step();
        mem_ack = 1'b0;
        check("idle_done_low", done, 1'b0);
        check("idle_busy_low", busy, 1'b0);
        check("idle_wben_low", wb_en, 1'b0);
        check("idle_err_low", err, 1'b0);
        check("idle_req_low", mem_req, 1'b0);
        if (exp_wben) check("idle_wb_hold", wb_data, last_wb);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'h0; alu_result = 16'h0;
        store_data = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wbdata", wb_data, 16'h0000);
        check("rst_memaddr", mem_addr, 16'h0000);
        step();
        step();
        rst_n = 1'b1;

        run_txn(OP_ADD, 16'h1234, 16'h0, 16'h0, 0, 1'b0);
        run_txn(OP_LBS, 16'h0011, 16'h0, 16'h80FF, 3, 1'b0);
        run_txn(OP_LBU, 16'h0011, 16'h0, 16'h80FF, 3, 1'b0);
        run_txn(OP_LW,  16'h0010, 16'h0, 16'h80FF, 0, 1'b0);
        run_txn(OP_LBS, 16'h0010, 16'h0, 16'h7F80, 0, 1'b0);
        run_txn(OP_SW,  16'h0020, 16'hBEEF, 16'h0, 1, 1'b1);
        run_txn(OP_LW,  16'h0003, 16'h0, 16'h0, 0, 1'b0);
        run_txn(OP_SW,  16'h0005, 16'h0, 16'h0, 0, 1'b0);
        run_txn(OP_LW,  16'h0040, 16'h0, 16'h0, 1000, 1'b0);
        run_txn(OP_LW,  16'h0042, 16'h0, 16'h5A5A, TIMEOUT - 1, 1'b0);

        // Reset in the middle of a request.
        start = 1'b1; op = OP_LW; alu_result = 16'h0080;
        step();
        start = 1'b0;
        check("mid_req_up", mem_req, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", mem_req, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_wbdata", wb_data, 16'h0000);
        last_wb = 16'h0000;
        step();
        check("rst_no_done", done, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_rst_no_done", done, 1'b0);
        run_txn(OP_ADD, 16'h00A5, 16'h0, 16'h0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic [3:0] ro;
            int dly;
            ro  = ($urandom_range(0, 1) == 1) ? 4'(8 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            dly = ($urandom_range(0, 7) == 0) ? TIMEOUT + 3 : $urandom_range(0, TIMEOUT - 1);
            run_txn(ro, 16'($urandom), 16'($urandom), 16'($urandom), dly, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of cycles mem_req waits for mem_ack.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse: ALU output valid, begin stage.
REQ-005 op  input  4  opcode in the shared constants encoding; LW, LBu, LBs and SW are memory ops, all others are non-memory ops.
REQ-006 alu_result  input  16  ALU output: the byte address for memory ops, the result otherwise.
REQ-007 store_data  input  16  value written by SW.
REQ-008 mem_rdata  input  16  read word from data memory.
REQ-009 mem_ack  input  1  memory completion, sampled only in REQ.
REQ-010 mem_req  output  1  memory request.
REQ-011 mem_we  output  1  1 = write (SW), 0 = read.
REQ-012 mem_addr  output  16  word-aligned address, {addr[15:1],0}.
REQ-013 mem_wdata  output  16  write data.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 wb_en  output  1  register writeback valid, qualified by done.
REQ-017 wb_data  output  16  writeback value.
REQ-018 err  output  1  error flag, qualified by done.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-020 In IDLE, the block SHALL accept start and register op, alu_result and store_data.
REQ-021 start SHALL be ignored outside IDLE, and registered inputs SHALL stay stable until IDLE.
REQ-022 A non-memory op SHALL move IDLE->DONE, with wb_data=alu_result, wb_en=1, err=0.
REQ-023 For a non-memory op, done SHALL rise on the cycle after start, giving a latency of 1.
REQ-024 LW or SW with addr[0]=1 SHALL move IDLE->DONE with no mem_req, err=1, wb_en=0.
REQ-025 An aligned memory op or any byte load SHALL move IDLE->REQ, asserting mem_req on the cycle after start.
REQ-026 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL be held constant until mem_ack is sampled high.
REQ-027 When mem_ack is sampled high in REQ, the FSM SHALL move REQ->DONE and mem_req SHALL deassert in the same edge.
REQ-028 For a memory op, done SHALL rise on the cycle after mem_ack, giving a latency of 2 with an immediate ack.
REQ-029 LW SHALL complete with wb_data=mem_rdata captured at ack, wb_en=1.
REQ-030 LBu SHALL select the byte lane by addr[0] (0 = bits 7:0, 1 = bits 15:8) and zero-extend it to 16 bits, wb_en=1.
REQ-031 LBs SHALL select the same byte lane as LBu and sign-extend bit 7 of the selected byte, wb_en=1.
REQ-032 SW SHALL drive mem_we=1 and mem_wdata=store_data, completing with wb_en=0, err=0.
REQ-033 If mem_ack is not seen within TIMEOUT cycles of REQ entry, mem_req SHALL drop, the FSM SHALL go to DONE, and err=1, wb_en=0.
REQ-034 Timeout counter: saturating, cleared on REQ entry; an ack in the same cycle as the final count SHALL win over timeout.
REQ-035 DONE SHALL last exactly one cycle, then DONE->IDLE.
REQ-036 In DONE, done=1 and wb_en, wb_data and err SHALL be valid; outside DONE, done, wb_en and err SHALL be 0 and wb_data SHALL hold its last value.
REQ-037 mem_ack SHALL be ignored in IDLE and DONE.
REQ-038 mem_we, mem_addr and mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-039 rst_n low SHALL immediately force state=IDLE and all outputs to 0, including mem_req, wb_data and the counter.
REQ-040 Reset during REQ SHALL abort the access with no done pulse.
REQ-041 After rst_n rises, the first start SHALL be accepted on the next clk edge.

Verification
REQ-042 op=ADD, alu_result=0x1234, start -> one cycle later: done=1, wb_en=1, wb_data=0x1234, mem_req never asserted.
REQ-043 op=LBs, alu_result=0x0011, mem_rdata=0x80FF, ack 3 cycles after mem_req -> mem_addr=0x0010, wb_data=0xFF80, done 1 cycle after ack.
REQ-044 op=LBu, same stimulus as REQ-043 -> wb_data=0x0080; op=LW, addr 0x0010 -> wb_data=0x80FF.
REQ-045 op=SW, alu_result=0x0020, store_data=0xBEEF, ack after 1 cycle -> mem_we=1, mem_wdata=0xBEEF, wb_en=0, err=0; a second start during REQ is ignored.
REQ-046 op=LW with addr 0x0003 -> err=1, no mem_req; op=LW with mem_ack never asserted -> mem_req drops after 15 cycles, done=1, err=1.
REQ-047 rst_n pulsed low mid-REQ -> mem_req=0 asynchronously, no done pulse, and the next start is processed normally.
